vigna_core: RTL and testbench
=============================

Name: vigna_core

Overview:
- Non-pipelined, multi-cycle RV32I integer core with separate instruction-fetch and data-memory buses.
- Each bus uses a valid/ready request handshake.
- The core fetches, decodes, executes and writes back one instruction at a time.
- It is the CPU block of the vigna SoC and connects directly to simple memory models or bus bridges.

Parameters:
- RESET_ADDR, 32'h0000_0000, PC value loaded at reset (first fetch address).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous active-low reset.
- i_valid  out  1  instruction fetch request.
- i_ready  in  1  fetch data valid / transfer complete.
- i_addr  out  32  fetch byte address (= PC, not masked).
- i_rdata  in  32  fetched instruction word.
- d_valid  out  1  data access request.
- d_ready  in  1  data transfer complete.
- d_addr  out  32  data byte address (rs1 + imm, full width).
- d_rdata  in  32  load data word.
- d_wdata  out  32  store data, lane-replicated.
- d_wstrb  out  4  byte write enables; 0 = read.

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-low (resetn).
- Reset (resetn=0 at a clk edge):
  - PC=RESET_ADDR, state=FETCH_IDLE.
  - i_valid=0, d_valid=0.
  - i_addr=RESET_ADDR, d_addr=0, d_wdata=0, d_wstrb=0.
  - Register file is not cleared; x0 always reads 0, writes to x0 are discarded.
  - Reset asserted mid-transaction aborts it immediately, with no writeback.
- Handshake, identical on both buses:
  - Address, wdata and wstrb are stable while valid=1.
  - A transfer completes on the first edge where valid=1 and ready=1; rdata is sampled at that edge.
  - valid drops on that same edge and stays low for at least one cycle.
  - A new request is asserted only when ready=0, since the slave holds ready until valid falls.
  - Unbounded wait states are tolerated.
- States:
  - FETCH: i_valid=1 with i_addr=PC. On completion, latch instruction → EXEC.
  - EXEC, 1 cycle: decode, read rs1/rs2, ALU, branch compare, compute next PC.
    - Loads/stores → MEM.
    - All other instructions: write rd, update PC → FETCH, with i_valid reasserted once i_ready=0.
  - MEM: d_valid=1. On completion:
    - Loads: extract/extend into rd.
    - PC+=4 → FETCH.
- Minimum cost per instruction: ALU ops take fetch handshake + 1 cycle; loads/stores add the data handshake.
- Supported instructions: full RV32I, i.e. LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, OP-IMM and OP (incl. SRA/SRAI, SLT/SLTU).
  - FENCE, ECALL, EBREAK, undefined opcodes and compressed encodings execute as NOP (PC+=4).
  - No CSRs, traps or interrupts.
- JALR target = (rs1+imm) & ~1. JALR x0,x0,-4 therefore fetches 0xFFFFFFFC; this is a normal fetch, not a halt.
- Branch and JAL targets are PC+imm, 32-bit wraparound, with no misalignment check.
- Stores:
  - SW: wstrb=1111, wdata=rs2.
  - SH: wstrb=0011<<addr[1]*2, wdata={2{rs2[15:0]}}.
  - SB: wstrb=0001<<addr[1:0], wdata={4{rs2[7:0]}}.
- Loads: wstrb=0; select byte lane via addr[1:0] (halfword via addr[1]); sign- or zero-extend per funct3.
- Misaligned accesses are not trapped; lane select uses the low address bits as above.
- Shifts use shamt[4:0]. All arithmetic is modulo 2^32.

Decomposition:
- vigna_pkg holds:
  - opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP);
  - funct3 codes;
  - the state enum (FETCH, EXEC, MEM).
- One sub-module, vigna_alu: combinational 32-bit ALU (add/sub/sll/slt/sltu/xor/srl/sra/or/and) plus branch comparator.
- Register file stays inline.

Test Plan:
- Reset→first fetch: hold resetn=0 10 cycles, release → i_valid=1 with i_addr=0x0 within 2 cycles; d_valid stays 0.
- Basic program: ADDI x1,x0,42; SW x1,0(x0); JALR x0,x0,-4 → exactly one write of addr 0, data 42, wstrb 1111; then i_addr=0xFFFFFFFC within 200 cycles.
- Byte/half: LUI x2,0x80000; ADDI x2,x2,0xF0; SB x2,5(x0); LB x3,5(x0); LBU x4,5(x0); SW both.
  - Required: SB has wstrb 0010 and wdata 0xF0F0F0F0.
  - Stored x3=0xFFFFFFF0, x4=0x000000F0.
- Branch/arith: x5=-1, x6=1; BLT x5,x6 taken (skips a store of 0xBAD); BLTU x5,x6 not taken; SRAI x5,1 → -1; SRLI x5,28 → 0xF.
  - All four results checked via SW.
- Handshake stress: memory inserts 0–5 random wait cycles and holds ready until valid drops.
  - Basic-program results are unchanged.
  - valid never reasserts while ready=1.
  - Address is stable throughout each request.
- Mid-fetch reset: assert resetn=0 while i_valid=1 → next edge i_valid=0; after release, fetch restarts at RESET_ADDR.

Source files
------------

// File: rtl/vigna_pkg.sv
// vigna_pkg: opcode/funct3 constants, FSM states, ALU ops and instruction field decode.
// Latency: none (types, constants and a pure decode function).
// Backpressure: not applicable.
package vigna_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // load / store funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // OP / OP-IMM funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       alt;     // instr[30]: SUB / SRA selector
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    d.opcode = ir[6:0];
    d.rd     = ir[11:7];
    d.funct3 = ir[14:12];
    d.rs1    = ir[19:15];
    d.rs2    = ir[24:20];
    d.alt    = ir[30];
    return d;
  endfunction

endpackage

// File: rtl/vigna_if.sv
// vigna_if: instruction-fetch and data-memory valid/ready buses of the core.
// Latency: none (wiring only).
// Backpressure: slave holds ready until the master drops valid; waits are unbounded.
interface vigna_if;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_addr;
  logic [31:0] d_rdata;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;

  modport master (
    output i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb,
    input  i_ready, i_rdata, d_ready, d_rdata
  );

  modport slave (
    input  i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb,
    output i_ready, i_rdata, d_ready, d_rdata
  );
endinterface

// File: rtl/vigna_alu.sv
// vigna_alu: 32-bit integer ALU plus branch comparator.
// Latency: purely combinational.
// Backpressure: none.
module vigna_alu
  import vigna_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  br_f3,
  input  logic [31:0] cmp_a,
  input  logic [31:0] cmp_b,
  output logic [31:0] y,
  output logic        br_taken
);

  // arithmetic / logic result; shifts only look at b[4:0]
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = '0;
    endcase
  end

  // branch decision; the two undefined funct3 codes never branch
  always_comb begin
    br_taken = 1'b0;
    case (br_f3)
      F3_BEQ:  br_taken = (cmp_a == cmp_b);
      F3_BNE:  br_taken = (cmp_a != cmp_b);
      F3_BLT:  br_taken = ($signed(cmp_a) < $signed(cmp_b));
      F3_BGE:  br_taken = !($signed(cmp_a) < $signed(cmp_b));
      F3_BLTU: br_taken = (cmp_a < cmp_b);
      F3_BGEU: br_taken = !(cmp_a < cmp_b);
      default: br_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/vigna_core.sv
// vigna_core: non-pipelined multi-cycle RV32I core, FETCH -> EXEC -> (MEM) -> FETCH.
// Latency: fetch handshake + 1 cycle per instruction, plus the data handshake for loads/stores.
// Backpressure: waits indefinitely on i_ready/d_ready; new requests only raised while ready is low.
module vigna_core
  import vigna_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic    clk,
  input  logic    resetn,
  vigna_if.master bus
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        i_valid_r;
  logic        d_valid_r;
  logic [31:0] d_addr_r;
  logic [31:0] d_wdata_r;
  logic [3:0]  d_wstrb_r;
  logic [31:0] rf [0:31];

  dec_t        dec;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] pc_plus4, mem_addr, next_pc, wb_val, alu_b, alu_y;
  logic [31:0] st_data, load_val;
  logic [3:0]  st_strb;
  logic        wb_en, br_taken, is_mem, is_store;
  alu_op_t     alu_op;
  logic        rf_we;
  logic [31:0] rf_wdata;

  assign bus.i_valid = i_valid_r;
  assign bus.i_addr  = pc;
  assign bus.d_valid = d_valid_r;
  assign bus.d_addr  = d_addr_r;
  assign bus.d_wdata = d_wdata_r;
  assign bus.d_wstrb = d_wstrb_r;

  assign dec     = decode(ir);
  assign rs1_val = (dec.rs1 == 5'd0) ? 32'd0 : rf[dec.rs1];
  assign rs2_val = (dec.rs2 == 5'd0) ? 32'd0 : rf[dec.rs2];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  assign is_store = (dec.opcode == OPC_STORE);
  assign is_mem   = is_store || (dec.opcode == OPC_LOAD);
  assign pc_plus4 = pc + 32'd4;
  // shared by loads, stores and JALR (JALR clears bit 0 afterwards)
  assign mem_addr = rs1_val + (is_store ? imm_s : imm_i);
  assign alu_b    = (dec.opcode == OPC_OP) ? rs2_val : imm_i;

  // map funct3 (+instr[30]) to an ALU operation; SUB only exists for register-register ops
  always_comb begin
    alu_op = ALU_ADD;
    case (dec.funct3)
      F3_ADD:  alu_op = (dec.opcode == OPC_OP && dec.alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:  alu_op = ALU_SLL;
      F3_SLT:  alu_op = ALU_SLT;
      F3_SLTU: alu_op = ALU_SLTU;
      F3_XOR:  alu_op = ALU_XOR;
      F3_SR:   alu_op = dec.alt ? ALU_SRA : ALU_SRL;
      F3_OR:   alu_op = ALU_OR;
      F3_AND:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

  vigna_alu u_alu (
    .op       (alu_op),
    .a        (rs1_val),
    .b        (alu_b),
    .br_f3    (dec.funct3),
    .cmp_a    (rs1_val),
    .cmp_b    (rs2_val),
    .y        (alu_y),
    .br_taken (br_taken)
  );

  // next PC and writeback for non-memory instructions; unknown opcodes fall through as NOP
  always_comb begin
    next_pc = pc_plus4;
    wb_en   = 1'b0;
    wb_val  = alu_y;
    case (dec.opcode)
      OPC_LUI:    begin wb_en = 1'b1; wb_val = imm_u; end
      OPC_AUIPC:  begin wb_en = 1'b1; wb_val = pc + imm_u; end
      OPC_JAL:    begin wb_en = 1'b1; wb_val = pc_plus4; next_pc = pc + imm_j; end
      OPC_JALR:   begin wb_en = 1'b1; wb_val = pc_plus4; next_pc = {mem_addr[31:1], 1'b0}; end
      OPC_BRANCH: if (br_taken) next_pc = pc + imm_b;
      OPC_OP,
      OPC_OP_IMM: wb_en = 1'b1;
      default:    ;
    endcase
  end

  // store lane replication and byte strobes from the low address bits
  always_comb begin
    st_data = rs2_val;
    st_strb = 4'b1111;
    case (dec.funct3)
      F3_SB: begin
        st_data = {4{rs2_val[7:0]}};
        st_strb = 4'b0001 << mem_addr[1:0];
      end
      F3_SH: begin
        st_data = {2{rs2_val[15:0]}};
        st_strb = 4'b0011 << {mem_addr[1], 1'b0};
      end
      default: ;
    endcase
  end

  // load lane select and extension; lane chosen from the latched request address
  always_comb begin
    logic [7:0]  lb;
    logic [15:0] lh;
    lb = bus.d_rdata[7:0];
    case (d_addr_r[1:0])
      2'd1:    lb = bus.d_rdata[15:8];
      2'd2:    lb = bus.d_rdata[23:16];
      2'd3:    lb = bus.d_rdata[31:24];
      default: lb = bus.d_rdata[7:0];
    endcase
    lh = d_addr_r[1] ? bus.d_rdata[31:16] : bus.d_rdata[15:0];
    case (dec.funct3)
      F3_LB:   load_val = {{24{lb[7]}}, lb};
      F3_LH:   load_val = {{16{lh[15]}}, lh};
      F3_LBU:  load_val = {24'b0, lb};
      F3_LHU:  load_val = {16'b0, lh};
      default: load_val = bus.d_rdata;
    endcase
  end

  // writeback: EXEC results, or load data on the data-bus completion edge; never during reset
  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = wb_val;
    if (resetn && dec.rd != 5'd0) begin
      if (state == ST_EXEC && wb_en) begin
        rf_we = 1'b1;
      end else if (state == ST_MEM && d_valid_r && bus.d_ready && !is_store) begin
        rf_we    = 1'b1;
        rf_wdata = load_val;
      end
    end
  end

  // register file has no reset; x0 is never written
  always_ff @(posedge clk) begin
    if (rf_we) rf[dec.rd] <= rf_wdata;
  end

  // control FSM with registered bus outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_FETCH;
      pc        <= RESET_ADDR;
      ir        <= 32'h0;
      i_valid_r <= 1'b0;
      d_valid_r <= 1'b0;
      d_addr_r  <= 32'h0;
      d_wdata_r <= 32'h0;
      d_wstrb_r <= 4'h0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (i_valid_r) begin
            if (bus.i_ready) begin
              ir        <= bus.i_rdata;
              i_valid_r <= 1'b0;
              state     <= ST_EXEC;
            end
          end else if (!bus.i_ready) begin
            i_valid_r <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (is_mem) begin
            d_addr_r  <= mem_addr;
            d_wdata_r <= st_data;
            d_wstrb_r <= is_store ? st_strb : 4'b0000;
            d_valid_r <= !bus.d_ready;
            state     <= ST_MEM;
          end else begin
            pc        <= next_pc;
            i_valid_r <= !bus.i_ready;
            state     <= ST_FETCH;
          end
        end
        ST_MEM: begin
          if (d_valid_r) begin
            if (bus.d_ready) begin
              d_valid_r <= 1'b0;
              pc        <= pc_plus4;
              i_valid_r <= !bus.i_ready;
              state     <= ST_FETCH;
            end
          end else if (!bus.d_ready) begin
            d_valid_r <= 1'b1;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_vigna_core.sv
// tb_vigna_core: directed programs against vigna_core with a word-addressed memory model.
// Latency: memory answers after 0 cycles, or 0-5 random wait cycles in stress mode.
// Backpressure: model holds ready until valid drops.
module tb_vigna_core;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_LD  = 7'b0000011;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  vigna_if bus ();

  vigna_core #(.RESET_ADDR(32'h0000_0000)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master)
  );

  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:63];
  logic [31:0] st_addr [$];
  logic [31:0] st_data [$];
  logic [3:0]  st_strb [$];
  bit          stress = 1'b0;
  int          prot_viol = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  // encoders
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [31:0] imm20, input logic [4:0] rd, input logic [6:0] op);
    return {imm20[19:0], rd, op};
  endfunction

  // memory responder plus protocol monitor, acting on the falling edge
  int          iwait = -1, dwait = -1;
  logic        i_prev = 1'b0, d_prev = 1'b0;
  logic [31:0] i_addr_q, d_addr_q, d_wdata_q;
  logic [3:0]  d_wstrb_q;
  always @(negedge clk) begin
    if (bus.i_valid === 1'b1 && !i_prev && bus.i_ready === 1'b1) prot_viol++;
    if (bus.d_valid === 1'b1 && !d_prev && bus.d_ready === 1'b1) prot_viol++;
    if (bus.i_valid === 1'b1 && i_prev && bus.i_addr !== i_addr_q) prot_viol++;
    if (bus.d_valid === 1'b1 && d_prev &&
        (bus.d_addr !== d_addr_q || bus.d_wdata !== d_wdata_q || bus.d_wstrb !== d_wstrb_q)) prot_viol++;
    i_prev = (bus.i_valid === 1'b1);
    d_prev = (bus.d_valid === 1'b1);
    i_addr_q = bus.i_addr;
    d_addr_q = bus.d_addr;
    d_wdata_q = bus.d_wdata;
    d_wstrb_q = bus.d_wstrb;

    if (bus.i_valid !== 1'b1) begin
      bus.i_ready = 1'b0;
      iwait = -1;
    end else if (bus.i_ready !== 1'b1) begin
      if (iwait < 0) iwait = stress ? int'($urandom_range(0, 5)) : 0;
      if (iwait == 0) begin
        bus.i_ready = 1'b1;
        bus.i_rdata = imem[bus.i_addr[7:2]];
      end else iwait--;
    end

    if (bus.d_valid !== 1'b1) begin
      bus.d_ready = 1'b0;
      dwait = -1;
    end else if (bus.d_ready !== 1'b1) begin
      if (dwait < 0) dwait = stress ? int'($urandom_range(0, 5)) : 0;
      if (dwait == 0) begin
        bus.d_ready = 1'b1;
        bus.d_rdata = dmem[bus.d_addr[7:2]];
        if (bus.d_wstrb != 4'b0000) begin
          for (int b = 0; b < 4; b++)
            if (bus.d_wstrb[b]) dmem[bus.d_addr[7:2]][8*b +: 8] = bus.d_wdata[8*b +: 8];
          st_addr.push_back(bus.d_addr);
          st_data.push_back(bus.d_wdata);
          st_strb.push_back(bus.d_wstrb);
        end
      end else dwait--;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 64; k++) begin
      imem[k] = 32'h0000_0013;
      dmem[k] = 32'h0;
    end
    imem[63] = 32'h0000_006F;  // JAL x0,0 parks the core at 0xFFFFFFFC
  endtask

  task automatic load_basic();
    clear_mem();
    imem[0] = enc_i(32'd42, 5'd0, 3'd0, 5'd1, OP_IMM);
    imem[1] = enc_s(32'd0, 5'd1, 5'd0, 3'b010);
    imem[2] = enc_i(-32'sd4, 5'd0, 3'd0, 5'd0, OP_JLR);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    resetn = 1'b0;
    repeat (cycles) @(negedge clk);
    st_addr.delete();
    st_data.delete();
    st_strb.delete();
    resetn = 1'b1;
  endtask

  task automatic run_to_park(input int budget, input string tag);
    bit hit = 1'b0;
    for (int k = 0; k < budget && !hit; k++) begin
      @(posedge clk); #1;
      if (bus.i_valid === 1'b1 && bus.i_addr === 32'hFFFF_FFFC) hit = 1'b1;
    end
    chk(tag, {31'b0, hit}, 32'd1);
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic chk_basic_stores(input string tag);
    chk({tag, "_nstore"}, st_addr.size(), 32'd1);
    if (st_addr.size() >= 1) begin
      chk({tag, "_addr"}, st_addr[0], 32'h0);
      chk({tag, "_data"}, st_data[0], 32'd42);
      chk({tag, "_strb"}, {28'b0, st_strb[0]}, 32'hF);
    end
  endtask

  task automatic first_fetch(input string tag);
    bit hit = 1'b0;
    for (int k = 0; k < 2 && !hit; k++) begin
      @(posedge clk); #1;
      if (bus.i_valid === 1'b1) hit = 1'b1;
    end
    chk({tag, "_ivalid"}, {31'b0, hit}, 32'd1);
    chk({tag, "_iaddr"}, bus.i_addr, 32'h0);
    chk({tag, "_dvalid"}, {31'b0, bus.d_valid}, 32'd0);
  endtask

  initial begin
    // reset state after 10 cycles of reset
    load_basic();
    bus.i_ready = 1'b0;
    bus.d_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_ivalid", {31'b0, bus.i_valid}, 32'd0);
    chk("rst_dvalid", {31'b0, bus.d_valid}, 32'd0);
    chk("rst_iaddr", bus.i_addr, 32'h0);
    chk("rst_daddr", bus.d_addr, 32'h0);
    chk("rst_dwdata", bus.d_wdata, 32'h0);
    chk("rst_dwstrb", {28'b0, bus.d_wstrb}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    first_fetch("ff");

    // basic program
    run_to_park(200, "basic_park");
    chk_basic_stores("basic");

    // byte / half
    clear_mem();
    imem[0] = enc_u(32'h80000, 5'd2, OP_LUI);
    imem[1] = enc_i(32'hF0, 5'd2, 3'd0, 5'd2, OP_IMM);
    imem[2] = enc_s(32'd5, 5'd2, 5'd0, 3'b000);
    imem[3] = enc_i(32'd5, 5'd0, 3'b000, 5'd3, OP_LD);
    imem[4] = enc_i(32'd5, 5'd0, 3'b100, 5'd4, OP_LD);
    imem[5] = enc_s(32'd8, 5'd3, 5'd0, 3'b010);
    imem[6] = enc_s(32'd12, 5'd4, 5'd0, 3'b010);
    imem[7] = enc_i(-32'sd4, 5'd0, 3'd0, 5'd0, OP_JLR);
    do_reset(3);
    run_to_park(400, "bh_park");
    chk("bh_nstore", st_addr.size(), 32'd3);
    if (st_addr.size() == 3) begin
      chk("sb_addr", st_addr[0], 32'd5);
      chk("sb_strb", {28'b0, st_strb[0]}, 32'b0010);
      chk("sb_data", st_data[0], 32'hF0F0_F0F0);
      chk("lb_addr", st_addr[1], 32'd8);
      chk("lb_val", st_data[1], 32'hFFFF_FFF0);
      chk("lbu_addr", st_addr[2], 32'd12);
      chk("lbu_val", st_data[2], 32'h0000_00F0);
    end

    // branch / arithmetic
    clear_mem();
    imem[0]  = enc_i(-32'sd1, 5'd0, 3'd0, 5'd5, OP_IMM);
    imem[1]  = enc_i(32'd1, 5'd0, 3'd0, 5'd6, OP_IMM);
    imem[2]  = enc_u(32'd1, 5'd7, OP_LUI);
    imem[3]  = enc_i(-32'sd1107, 5'd7, 3'd0, 5'd7, OP_IMM);
    imem[4]  = enc_i(32'd7, 5'd0, 3'd0, 5'd8, OP_IMM);
    imem[5]  = enc_b(32'd8, 5'd6, 5'd5, 3'b100);          // BLT  -> taken
    imem[6]  = enc_s(32'h20, 5'd7, 5'd0, 3'b010);         // SW 0xBAD, skipped
    imem[7]  = enc_b(32'd8, 5'd6, 5'd5, 3'b110);          // BLTU -> not taken
    imem[8]  = enc_i(32'd1, 5'd0, 3'd0, 5'd8, OP_IMM);
    imem[9]  = enc_s(32'h24, 5'd8, 5'd0, 3'b010);
    imem[10] = enc_i(32'h401, 5'd5, 3'b101, 5'd9, OP_IMM); // SRAI x9,x5,1
    imem[11] = enc_i(32'd28, 5'd5, 3'b101, 5'd10, OP_IMM); // SRLI x10,x5,28
    imem[12] = enc_s(32'h28, 5'd9, 5'd0, 3'b010);
    imem[13] = enc_s(32'h2C, 5'd10, 5'd0, 3'b010);
    imem[14] = enc_i(-32'sd4, 5'd0, 3'd0, 5'd0, OP_JLR);
    do_reset(3);
    run_to_park(600, "br_park");
    chk("br_nstore", st_addr.size(), 32'd3);
    if (st_addr.size() == 3) begin
      chk("blt_skip_addr", st_addr[0], 32'h24);
      chk("bltu_nt_val", st_data[0], 32'd1);
      chk("srai_val", st_data[1], 32'hFFFF_FFFF);
      chk("srli_val", st_data[2], 32'h0000_000F);
    end

    // handshake stress on the basic program
    load_basic();
    stress = 1'b1;
    prot_viol = 0;
    do_reset(3);
    run_to_park(2000, "stress_park");
    chk_basic_stores("stress");
    chk("stress_protocol", prot_viol, 32'd0);
    stress = 1'b0;

    // reset while a fetch is outstanding
    load_basic();
    do_reset(3);
    begin
      bit hit = 1'b0;
      for (int k = 0; k < 50 && !hit; k++) begin
        @(posedge clk); #1;
        if (bus.i_valid === 1'b1 && bus.i_addr === 32'h4) hit = 1'b1;
      end
      chk("mid_reach_fetch", {31'b0, hit}, 32'd1);
    end
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("mid_ivalid_drop", {31'b0, bus.i_valid}, 32'd0);
    chk("mid_iaddr_reset", bus.i_addr, 32'h0);
    chk("mid_no_store", st_addr.size(), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    first_fetch("mid_ff");
    run_to_park(200, "mid_park");
    chk_basic_stores("mid");
    chk("final_protocol", prot_viol, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
